// File: rtl/game_timer_pkg.sv
// Shared types, level constants and sizing helpers for the game round timer.
package game_timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        ARM,
        RUN,
        PAUSED,
        EXPIRED
    } state_e;

    localparam int unsigned LVL_W = 4;

    localparam logic [LVL_W-1:0] LVL_99  = 4'd0;
    localparam logic [LVL_W-1:0] LVL_60  = 4'd1;
    localparam logic [LVL_W-1:0] LVL_45  = 4'd2;
    localparam logic [LVL_W-1:0] LVL_MAX = 4'd2;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned calc_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Unsupported level codes fall back to the shortest round.
    function automatic logic [LVL_W-1:0] clamp_level(input logic [LVL_W-1:0] lvl);
        return (lvl > LVL_MAX) ? LVL_MAX : lvl;
    endfunction

endpackage

// File: rtl/game_timer_ctrl_tick_prescaler.sv
// Free-running divide-by-DIV counter; wrap_c flags the enabled cycle at DIV-1.
module tick_prescaler
    import game_timer_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap_c
);

    localparam int unsigned PW = calc_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + PW'(1);
        end
    end

    assign wrap_c = enable && !clear && (count_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round sequencer and 1 Hz tick source for the cascaded BCD digit timers.
// Pause/resume is built only when GAME_TIMER_PAUSE_EN is defined.
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned TICK_HZ     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic [LVL_W-1:0] level_sel,
    input  logic             timeout_n,
    output logic             tick,
    output logic             reconfig,
    output logic [LVL_W-1:0] difficulty,
    output logic             timer_reset_n,
    output logic             running,
    output logic             expired
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);

    state_e           state_q, state_d;
    logic [LVL_W-1:0] difficulty_q, difficulty_d;
    logic             tick_q, reconfig_q, timer_reset_n_q, running_q, expired_q;
    logic             ps_clear_c, ps_enable_c, wrap_c;

`ifndef GAME_TIMER_PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause;
`endif

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (ps_clear_c),
        .enable(ps_enable_c),
        .wrap_c(wrap_c)
    );

    // Next state; the prescaler only advances on RUN cycles with no higher-priority event.
    always_comb begin
        state_d      = state_q;
        difficulty_d = difficulty_q;
        ps_enable_c  = 1'b0;
        ps_clear_c   = (state_q == ARM);
        if (start) begin
            state_d      = CLEAR;
            difficulty_d = clamp_level(level_sel);
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                CLEAR:   state_d = LOAD;
                LOAD:    state_d = ARM;
                ARM:     state_d = RUN;
                RUN: begin
                    if (!timeout_n) begin
                        state_d = EXPIRED;
                    end
`ifdef GAME_TIMER_PAUSE_EN
                    else if (pause) begin
                        state_d = PAUSED;
                    end
`endif
                    else begin
                        ps_enable_c = 1'b1;
                    end
                end
`ifdef GAME_TIMER_PAUSE_EN
                PAUSED: begin
                    if (pause) begin
                        state_d = RUN;
                    end
                end
`endif
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            difficulty_q    <= '0;
            tick_q          <= 1'b0;
            reconfig_q      <= 1'b0;
            timer_reset_n_q <= 1'b1;
            running_q       <= 1'b0;
            expired_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            difficulty_q    <= difficulty_d;
            tick_q          <= wrap_c;
            reconfig_q      <= (state_d == LOAD);
            timer_reset_n_q <= (state_d != CLEAR);
            running_q       <= (state_d == RUN);
            expired_q       <= (state_d == EXPIRED);
        end
    end

    assign tick          = tick_q;
    assign reconfig      = reconfig_q;
    assign difficulty    = difficulty_q;
    assign timer_reset_n = timer_reset_n_q;
    assign running       = running_q;
    assign expired       = expired_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed round scenarios then random traffic against a round model.
module tb_game_timer_ctrl;

    localparam int DIV = 10;
`ifdef GAME_TIMER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_LOAD   = 2;
    localparam int P_ARM    = 3;
    localparam int P_RUN    = 4;
    localparam int P_PAUSED = 5;
    localparam int P_EXP    = 6;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic [3:0] level_sel;
    logic       timeout_n;
    logic       tick;
    logic       reconfig;
    logic [3:0] difficulty;
    logic       timer_reset_n;
    logic       running;
    logic       expired;

    game_timer_ctrl #(
        .CLK_FREQ_HZ(10),
        .TICK_HZ    (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .level_sel    (level_sel),
        .timeout_n    (timeout_n),
        .tick         (tick),
        .reconfig     (reconfig),
        .difficulty   (difficulty),
        .timer_reset_n(timer_reset_n),
        .running      (running),
        .expired      (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Round model: phase of the round plus seconds-worth of RUN cycles consumed.
    int m_phase;
    int m_elapsed;
    int m_diff;
    int m_tick;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_elapsed = 0;
        m_diff    = 0;
        m_tick    = 0;
    endtask

    task automatic model_step(input logic st, input logic pa, input logic [3:0] lv, input logic tn);
        m_tick = 0;
        if (st) begin
            m_phase = P_CLEAR;
            m_diff  = (lv > 4'd2) ? 2 : int'(lv);
        end else begin
            case (m_phase)
                P_CLEAR: m_phase = P_LOAD;
                P_LOAD:  m_phase = P_ARM;
                P_ARM: begin
                    m_phase   = P_RUN;
                    m_elapsed = 0;
                end
                P_RUN: begin
                    if (!tn) begin
                        m_phase = P_EXP;
                    end else if (pa && PAUSE_EN) begin
                        m_phase = P_PAUSED;
                    end else begin
                        m_elapsed++;
                        m_tick = (m_elapsed % DIV == 0) ? 1 : 0;
                    end
                end
                P_PAUSED: if (pa) m_phase = P_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("tick",          int'(tick),          m_tick);
        chk("reconfig",      int'(reconfig),      (m_phase == P_LOAD) ? 1 : 0);
        chk("difficulty",    int'(difficulty),    m_diff);
        chk("timer_reset_n", int'(timer_reset_n), (m_phase == P_CLEAR) ? 0 : 1);
        chk("running",       int'(running),       (m_phase == P_RUN) ? 1 : 0);
        chk("expired",       int'(expired),       (m_phase == P_EXP) ? 1 : 0);
    endtask

    // Inputs change just after a falling edge, outputs are checked at the next falling edge.
    task automatic drive_cycle(input logic st, input logic pa, input logic [3:0] lv, input logic tn);
        start     = st;
        pause     = pa;
        level_sel = lv;
        timeout_n = tn;
        model_step(st, pa, lv, tn);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n, input logic tn);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 4'd0, tn);
    endtask

    initial begin
        int run_at;
        int t1;
        int t2;
        int tick_cnt;

        reset     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        level_sel = 4'd0;
        timeout_n = 1'b1;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(3, 1'b1);

        // Level 1 round: sequencing and tick cadence
        cyc    = 0;
        run_at = -1;
        t1     = -1;
        t2     = -1;
        drive_cycle(1'b1, 1'b0, 4'd1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 1'b0, 4'd1, 1'b1);
            if (running && run_at < 0) run_at = cyc;
            if (tick) begin
                if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
            end
        end
        chk("run_entry_cycle", run_at, 4);
        chk("first_tick_gap", t1 - run_at, DIV);
        chk("tick_period", t2 - t1, DIV);
        chk("difficulty_lvl1", int'(difficulty), 1);

        // Out-of-range level clamps
        drive_cycle(1'b1, 1'b0, 4'd7, 1'b1);
        chk("difficulty_clamp", int'(difficulty), 2);
        idle_cycles(15, 1'b1);

        // Pause with the prescaler at 4, hold 25 cycles, resume
        drive_cycle(1'b1, 1'b0, 4'd0, 1'b1);
        idle_cycles(7, 1'b1);
        drive_cycle(1'b0, 1'b1, 4'd0, 1'b1);
        idle_cycles(25, 1'b1);
        drive_cycle(1'b0, 1'b1, 4'd0, 1'b1);
        idle_cycles(25, 1'b1);

        // Timeout on the prescaler-9 cycle suppresses that tick
        drive_cycle(1'b1, 1'b0, 4'd0, 1'b1);
        idle_cycles(12, 1'b1);
        drive_cycle(1'b0, 1'b0, 4'd0, 1'b0);
        chk("expired_after_timeout", int'(expired), 1);
        chk("running_after_timeout", int'(running), 0);
        chk("tick_on_timeout", int'(tick), 0);
        tick_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, 1'b0, 4'd0, 1'b0);
            tick_cnt += int'(tick);
        end
        chk("ticks_while_expired", tick_cnt, 0);

        // Restart from EXPIRED with timeout still low, released after CLEAR
        drive_cycle(1'b1, 1'b0, 4'd2, 1'b0);
        chk("clear_from_expired", int'(timer_reset_n), 0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 4'd2, 1'b1);
        chk("running_after_restart", int'(running), 1);

        // Asynchronous reset mid-RUN
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        idle_cycles(3, 1'b1);
        chk("idle_after_reset", int'(running), 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(($urandom_range(0, 59) == 0),
                        ($urandom_range(0, 7) == 0),
                        4'($urandom_range(0, 15)),
                        ($urandom_range(0, 79) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
